s_mux_pipe: RTL and testbench

//  Parametrised successor of the mux-plus-register logic cell. Selects one of 2**SELW
//  N-bit inputs, using select bits derived from gated control pairs.

---
 rtl/s_mux_pipe.sv | 150 +++++++++++++++
 tb/tb_s_mux_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mux_pipe.sv
// s_mux_pipe: selects one of 2**SELW N-bit words using gated select pairs
// and carries the selected word through a DEPTH-stage elastic valid/ready
// pipeline with synchronous active-low reset (clr) and functional flush (sclr).
module s_mux_pipe #(
    parameter int              N      = 8,
    parameter int              SELW   = 2,
    parameter logic [SELW-1:0] SEL_OP = 2'b01,
    parameter int              DEPTH  = 2,
    localparam int             K      = 2 ** SELW,
    localparam int             OCCW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [K*N-1:0]    d,
    input  logic [SELW-1:0]   sa,
    input  logic [SELW-1:0]   sb,
    input  logic              sclr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N-1:0]      out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OCCW-1:0]   occupancy
);

    logic [SELW-1:0] sel;
    logic [N-1:0]    d_word [K];
    logic [N-1:0]    word;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [N-1:0]     data_q [DEPTH];
    logic [OCCW-1:0]  occ_q;
    logic [OCCW-1:0]  occ_d;

    // ready[k]: stage k may take a new value this cycle; ready[DEPTH] is the consumer
    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] load;
    logic             take;

    // Per-bit gating of the two select operands: 1 -> AND, 0 -> OR.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        sel = '0;
        for (int i = 0; i < SELW; i++) begin
            sel[i] = SEL_OP[i] ? (sa[i] & sb[i]) : (sa[i] | sb[i]);
        end
    end

    // Unpack the input bus into words and pick the selected one; no register here.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            d_word[j] = d[j*N +: N];
        end
        word = d_word[sel];
    end

    // Ready chain: a stage can advance unless it and every stage after it are full
    // while the consumer is stalled. Written as a running AND to avoid a self-loop.
    always_comb begin
        logic full_tail;
        full_tail    = 1'b1;
        ready        = '0;
        ready[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full_tail = full_tail & valid_q[k];
            ready[k]  = ~full_tail | out_ready;
        end
    end

    assign in_ready = clr & ~sclr & ready[0];
    assign take     = in_valid & in_ready;

    // Data-load enables: a stage loads only when a valid word moves into it.
    always_comb begin
        load    = '0;
        load[0] = take;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = ~sclr & ready[k] & valid_q[k-1];
        end
    end

    // Next valids (flush clears all) and the matching popcount for occupancy.
    always_comb begin
        valid_d = valid_q;
        occ_d   = '0;
        if (sclr) begin
            valid_d = '0;
        end else begin
            if (ready[0]) begin
                valid_d[0] = take;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ready[k]) begin
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCCW'(valid_d[k]);
        end
    end

    // Valid flags and occupancy register; clr clears both.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every stage samples pre-edge values;
        // blocking assignments here would let a word ripple through several stages.
        if (!clr) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Stage data registers; an empty stage with an empty predecessor keeps its data.
    always_ff @(posedge clk) begin
        // NOTE: the data array is reset deliberately because out must read 0 after
        // reset; flush leaves it untouched and only drops the valids.
        if (!clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                data_q[0] <= word;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign out       = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign occupancy = occ_q;

    // Occupancy can never exceed the number of stages.
    occ_bound_a: assert property (@(posedge clk) disable iff (!clr)
        occupancy <= OCCW'(DEPTH));

    // A stalled output word holds until it is taken or flushed.
    stall_hold_a: assert property (@(posedge clk) disable iff (!clr)
        (out_valid && !out_ready && !sclr) |=> (out_valid && $stable(out)));

endmodule

// File: tb/tb_s_mux_pipe.sv
// Testbench for s_mux_pipe: directed scenarios plus random traffic, checked
// against an item-position queue model of the elastic pipeline.
module tb_s_mux_pipe;

    localparam int              N      = 8;
    localparam int              SELW   = 2;
    localparam int              K      = 2 ** SELW;
    localparam int              DEPTH  = 2;
    localparam int              OCCW   = $clog2(DEPTH + 1);
    localparam logic [SELW-1:0] SEL_OP = 2'b01;

    logic            clk;
    logic            clr;
    logic [K*N-1:0]  d;
    logic [SELW-1:0] sa;
    logic [SELW-1:0] sb;
    logic            sclr;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    out;
    logic            out_valid;
    logic            out_ready;
    logic [OCCW-1:0] occupancy;

    s_mux_pipe #(
        .N      (N),
        .SELW   (SELW),
        .SEL_OP (SEL_OP),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .d         (d),
        .sa        (sa),
        .sb        (sb),
        .sclr      (sclr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: words in flight, oldest first, each with its stage position.
    int           q_pos [$];
    logic [N-1:0] q_dat [$];
    logic [N-1:0] m_last = '0;

    function automatic logic [N-1:0] pick();
        logic [SELW-1:0] s;
        s = (sa & sb & SEL_OP) | ((sa | sb) & ~SEL_OP);
        return N'(d >> (int'(s) * N));
    endfunction

    // Entry is possible when a slot is free or the head leaves this cycle.
    function automatic bit m_in_ready();
        return (clr === 1'b1) && (sclr === 1'b0) &&
               (q_pos.size() < DEPTH || out_ready === 1'b1);
    endfunction

    function automatic bit m_out_valid();
        return (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void model_edge();
        bit acc;
        bit leave;
        int limit;
        acc = m_in_ready() && (in_valid === 1'b1);
        if (clr !== 1'b1) begin
            q_pos.delete();
            q_dat.delete();
            m_last = '0;
            return;
        end
        if (sclr === 1'b1) begin
            q_pos.delete();
            q_dat.delete();
            return;
        end
        limit = DEPTH;
        leave = 1'b0;
        for (int i = 0; i < q_pos.size(); i++) begin
            if (q_pos[i] == DEPTH - 1) begin
                if (out_ready === 1'b1) leave = 1'b1;
                else                    limit = DEPTH - 1;
            end else begin
                if (q_pos[i] + 1 < limit) begin
                    q_pos[i] = q_pos[i] + 1;
                    if (q_pos[i] == DEPTH - 1) m_last = q_dat[i];
                end
                limit = q_pos[i];
            end
        end
        if (leave) begin
            void'(q_pos.pop_front());
            void'(q_dat.pop_front());
        end
        if (acc) begin
            q_pos.push_back(0);
            q_dat.push_back(pick());
            if (DEPTH == 1) m_last = pick();
        end
    endfunction

    // One clock: check in_ready before the edge, outputs shortly after it.
    task automatic cycle();
        #1;
        check("in_ready", in_ready, m_in_ready());
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", out_valid, m_out_valid());
        check("occupancy", occupancy, q_pos.size());
        check("out", out, m_last);
    endtask

    task automatic drain();
        clr = 1'b1; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
    endtask

    logic [N-1:0] got [$];
    int           w;
    bit           accepted;

    initial begin
        clr = 1'b0; sclr = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        d = 32'hDEAD_BEEF; sa = '0; sb = '0;

        // Reset held two cycles with input offered.
        repeat (2) cycle();
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 0);

        // Select: sel = {1|0, 0&1} = 2'b10 -> 8'h33 two edges later.
        clr = 1'b1; d = 32'h4433_2211; sa = 2'b10; sb = 2'b01;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("sel_out", out, 8'h33);
        check("sel_out_valid", out_valid, 1);
        drain();
        // Other select patterns: 11&01 -> sel=2'b11 -> 8'h44, 00/00 -> 8'h11.
        sa = 2'b11; sb = 2'b01; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("sel3_out", out, 8'h44);
        sa = 2'b00; sb = 2'b00; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("sel0_out", out, 8'h11);
        drain();

        // Stream: 6 words back-to-back with consumer always ready.
        got.delete();
        sa = '0; sb = '0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 6);
            d = {24'h0, 8'(i + 1)};
            cycle();
            if (i == 1) begin
                check("stream_latency_valid", out_valid, 1);
                check("stream_latency_out", out, 1);
            end
            if (out_valid === 1'b1) got.push_back(out);
        end
        check("stream_count", got.size(), 6);
        for (int i = 0; i < 6; i++) check("stream_word", got[i], i + 1);
        drain();

        // Stall: consumer stalled while 4 words are offered.
        out_ready = 1'b0; w = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            d = {24'h0, 8'(w)};
            accepted = m_in_ready();
            cycle();
            if (accepted) w++;
        end
        check("stall_occupancy", occupancy, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out", out, 1);
        got.delete();
        got.push_back(out);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (w <= 4);
            d = {24'h0, 8'(w)};
            accepted = m_in_ready() && in_valid;
            cycle();
            if (accepted) w++;
            if (out_valid === 1'b1) got.push_back(out);
        end
        check("stall_accepted", w, 5);
        check("stall_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check("stall_word", got[i], i + 1);
        drain();

        // Flush: full pipe, sclr for one cycle with a word offered.
        out_ready = 1'b0; in_valid = 1'b1;
        d = {24'h0, 8'h07}; cycle();
        d = {24'h0, 8'h08}; cycle();
        check("flush_pre_out", out, 8'h07);
        check("flush_pre_occupancy", occupancy, 2);
        sclr = 1'b1; d = {24'h0, 8'h09};
        cycle();
        check("flush_out_valid", out_valid, 0);
        check("flush_occupancy", occupancy, 0);
        check("flush_out_kept", out, 8'h07);
        sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check("flush_no_late_word", out_valid, 0);
        check("flush_out_still", out, 8'h07);

        // Reset and flush together: reset wins and zeroes data.
        out_ready = 1'b0; in_valid = 1'b1;
        d = {24'h0, 8'h05}; cycle();
        d = {24'h0, 8'h06}; cycle();
        clr = 1'b0; sclr = 1'b1;
        cycle();
        check("clr_sclr_out", out, 0);
        check("clr_sclr_occupancy", occupancy, 0);
        drain();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            clr       = ($urandom_range(99) != 0);
            sclr      = ($urandom_range(29) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            d         = $urandom;
            sa        = SELW'($urandom);
            sb        = SELW'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
